// File: rtl/seq_divider_20b_if.sv
// Operand and result handshake bundle for seq_divider_20b.
// The master side drives operands and out_ready; the slave side is the divider.
interface seq_divider_20b_if #(
   parameter int DW = 20,
   parameter int SW = 12
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [SW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output in_valid,
      output dividend,
      output divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  in_valid,
      input  dividend,
      input  divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/seq_divider_20b.sv
// Restoring divider for normalising accumulated pixel sums.
// One quotient bit per cycle; a single operation in flight at a time.
module seq_divider_20b #(
   parameter int DW = 20,
   parameter int SW = 12
) (
   input  logic           clk,
   input  logic           rst,
   seq_divider_20b_if.slave bus
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   logic [SW-1:0] part;
   logic [DW-1:0] qreg;
   logic [SW-1:0] dsr;
   logic [CW-1:0] cnt;

   logic [DW-1:0] quo_q;
   logic [SW-1:0] rem_q;
   logic          dz_q;
   logic          ov_q;

   logic [SW:0]   shifted;
   logic [SW-1:0] trial;
   logic          fits;
   logic [SW-1:0] part_nx;
   logic [DW-1:0] qreg_nx;

   // Partial is always below the divisor, so the SW+1-bit shift never
   // overflows and the difference always fits back into SW bits.
   always_comb begin
      shifted = {part, qreg[DW-1]};
      fits    = (shifted >= {1'b0, dsr});
      trial   = shifted[SW-1:0] - dsr;
      part_nx = fits ? trial : shifted[SW-1:0];
      qreg_nx = {qreg[DW-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         part  <= '0;
         qreg  <= '0;
         dsr   <= '0;
         cnt   <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dz_q  <= 1'b0;
         ov_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  dsr <= bus.divisor;
                  if (bus.divisor == '0) begin
                     state <= DONE;
                     quo_q <= '1;
                     rem_q <= '0;
                     dz_q  <= 1'b1;
                     ov_q  <= 1'b1;
                  end else begin
                     state <= BUSY;
                     part  <= '0;
                     qreg  <= bus.dividend;
                     cnt   <= CW'(DW - 1);
                  end
               end
            end
            BUSY: begin
               part <= part_nx;
               qreg <= qreg_nx;
               if (cnt == '0) begin
                  state <= DONE;
                  quo_q <= qreg_nx;
                  rem_q <= part_nx;
                  dz_q  <= 1'b0;
                  ov_q  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  ov_q  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE) && !rst;
   assign bus.out_valid   = ov_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_20b.sv
// Self-checking bench for seq_divider_20b against a plain-arithmetic model.
module tb_seq_divider_20b;

   localparam int DW = 20;
   localparam int SW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_divider_20b_if #(.DW(DW), .SW(SW)) bus ();

   seq_divider_20b #(.DW(DW), .SW(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic void model(
      input  logic [DW-1:0] a,
      input  logic [SW-1:0] b,
      output logic [DW-1:0] q,
      output logic [SW-1:0] r,
      output logic          dz,
      output int            lat
   );
      if (b == 0) begin
         q = '1; r = '0; dz = 1'b1; lat = 1;
      end else begin
         q = a / b; r = SW'(a % b); dz = 1'b0; lat = DW + 1;
      end
   endfunction

   // Drives one operation; must be entered 1 time unit after a rising edge.
   task automatic run_op(
      input  logic [DW-1:0] a,
      input  logic [SW-1:0] b,
      input  int            stall,
      output logic [DW-1:0] q,
      output logic [SW-1:0] r,
      output logic          dz,
      output int            lat,
      output int            unstable,
      output logic          post_ov,
      output logic          post_ir,
      output bit            tmo
   );
      int w;
      tmo = 0; unstable = 0; lat = 0;
      q = '0; r = '0; dz = 1'b0; post_ov = 1'b0; post_ir = 1'b0;
      bus.out_ready = (stall == 0);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 100) begin tmo = 1; return; end
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.dividend = DW'($urandom);
      bus.divisor  = SW'($urandom);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      if (lat >= 100) begin tmo = 1; return; end
      q  = bus.quotient;
      r  = bus.remainder;
      dz = bus.div_by_zero;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.quotient !== q ||
             bus.remainder !== r || bus.div_by_zero !== dz ||
             bus.in_ready !== 1'b0)
            unstable++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      post_ov = bus.out_valid;
      post_ir = bus.in_ready;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got ov=%b dz=%b expected 0 0",
                  bus.out_valid, bus.div_by_zero);
      end
      checks++;
      if (bus.quotient !== '0 || bus.remainder !== '0) begin
         errors++;
         $display("FAIL reset_data: got q=%0d r=%0d expected 0 0",
                  bus.quotient, bus.remainder);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] q; logic [SW-1:0] r; logic dz, pov, pir;
      int lat, uns; bit tmo;
      run_op(20'd1000, 12'd7, 0, q, r, dz, lat, uns, pov, pir, tmo);
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL basic_timeout: got timeout expected result");
         return;
      end
      checks++;
      if (q !== 20'd142 || r !== 12'd6 || dz !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected 142 6 0",
                  q, r, dz);
      end
      checks++;
      if (lat != 21) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected 21", lat);
      end
      checks++;
      if (pov !== 1'b0 || pir !== 1'b1) begin
         errors++;
         $display("FAIL basic_one_cycle: got ov=%b ir=%b expected 0 1", pov, pir);
      end
   endtask

   task automatic test_extremes();
      logic [DW-1:0] ta [3] = '{20'd1048575, 20'd1048575, 20'd5};
      logic [SW-1:0] tb [3] = '{12'd1, 12'd4095, 12'd4095};
      logic [DW-1:0] tq [3] = '{20'd1048575, 20'd256, 20'd0};
      logic [SW-1:0] tr [3] = '{12'd0, 12'd255, 12'd5};
      logic [DW-1:0] q; logic [SW-1:0] r; logic dz, pov, pir;
      int lat, uns; bit tmo;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tb[i], 0, q, r, dz, lat, uns, pov, pir, tmo);
         checks++;
         if (tmo || q !== tq[i] || r !== tr[i] || dz !== 1'b0 || lat != 21) begin
            errors++;
            $display("FAIL extreme_%0d: got q=%0d r=%0d dz=%b lat=%0d tmo=%0d expected %0d %0d 0 21",
                     i, q, r, dz, lat, tmo, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [DW-1:0] q; logic [SW-1:0] r; logic dz, pov, pir;
      int lat, uns; bit tmo;
      run_op(20'd1234, 12'd0, 0, q, r, dz, lat, uns, pov, pir, tmo);
      checks++;
      if (tmo || q !== 20'hFFFFF || r !== 12'd0 || dz !== 1'b1) begin
         errors++;
         $display("FAIL div_zero_result: got q=%0h r=%0d dz=%b expected fffff 0 1",
                  q, r, dz);
      end
      checks++;
      if (lat != 1 || pov !== 1'b0) begin
         errors++;
         $display("FAIL div_zero_timing: got lat=%0d ov_after=%b expected 1 0",
                  lat, pov);
      end
      run_op(20'd77, 12'd5, 0, q, r, dz, lat, uns, pov, pir, tmo);
      checks++;
      if (tmo || q !== 20'd15 || r !== 12'd2 || dz !== 1'b0) begin
         errors++;
         $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b expected 15 2 0",
                  q, r, dz);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] q; logic [SW-1:0] r; logic dz, pov, pir;
      int lat, uns; bit tmo;
      run_op(20'd500, 12'd3, 5, q, r, dz, lat, uns, pov, pir, tmo);
      checks++;
      if (tmo || q !== 20'd166 || r !== 12'd2 || dz !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: got q=%0d r=%0d dz=%b expected 166 2 0",
                  q, r, dz);
      end
      checks++;
      if (uns != 0) begin
         errors++;
         $display("FAIL bp_hold: got %0d unstable cycles expected 0", uns);
      end
      checks++;
      if (pov !== 1'b0 || pir !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", pov, pir);
      end
   endtask

   task automatic test_handshake();
      logic [DW-1:0] qa [$];
      logic [SW-1:0] qb [$];
      int            acc [$];
      logic [DW-1:0] eq, a; logic [SW-1:0] er, b; logic edz;
      int nres = 0, cyc = 0, bad_ir = 0, elat;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      while (nres < 3 && cyc < 300) begin
         bus.dividend = DW'($urandom);
         bus.divisor  = SW'($urandom_range(1, 4095));
         if (bus.in_ready === 1'b1) begin
            qa.push_back(bus.dividend);
            qb.push_back(bus.divisor);
            acc.push_back(cyc);
         end
         if (bus.out_valid === 1'b1) begin
            nres++;
            if (bus.in_ready !== 1'b0) bad_ir++;
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL hs_spurious: got result with no accepted operands expected none");
            end else begin
               a = qa.pop_front();
               b = qb.pop_front();
               model(a, b, eq, er, edz, elat);
               if (bus.quotient !== eq || bus.remainder !== er ||
                   bus.div_by_zero !== edz) begin
                  errors++;
                  $display("FAIL hs_result: %0d/%0d got q=%0d r=%0d expected %0d %0d",
                           a, b, bus.quotient, bus.remainder, eq, er);
               end
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (nres != 3 || acc.size() != 3 || qa.size() != 0) begin
         errors++;
         $display("FAIL hs_count: got results=%0d accepts=%0d pending=%0d expected 3 3 0",
                  nres, acc.size(), qa.size());
      end else begin
         checks++;
         if (acc[1] - acc[0] != 22 || acc[2] - acc[1] != 22) begin
            errors++;
            $display("FAIL hs_spacing: got %0d %0d expected 22 22",
                     acc[1] - acc[0], acc[2] - acc[1]);
         end
      end
      checks++;
      if (bad_ir != 0) begin
         errors++;
         $display("FAIL hs_ready_in_done: got %0d expected 0", bad_ir);
      end
   endtask

   task automatic test_reset_midop();
      logic [DW-1:0] q; logic [SW-1:0] r; logic dz, pov, pir;
      int lat, uns, seen = 0; bit tmo;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.dividend  = 20'd1000;
      bus.divisor   = 12'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
          bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: got ov=%b q=%0d r=%0d dz=%b expected 0 0 0 0",
                  bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_ready: got %b expected 1", bus.in_ready);
      end
      repeat (25) begin
         if (bus.out_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
      end
      run_op(20'd100, 12'd9, 0, q, r, dz, lat, uns, pov, pir, tmo);
      checks++;
      if (tmo || q !== 20'd11 || r !== 12'd1 || dz !== 1'b0 || lat != 21) begin
         errors++;
         $display("FAIL midrst_after: got q=%0d r=%0d dz=%b lat=%0d expected 11 1 0 21",
                  q, r, dz, lat);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] a, q, eq; logic [SW-1:0] b, r, er; logic dz, edz, pov, pir;
      int lat, elat, uns, stall, mode; bit tmo;
      for (int n = 0; n < 40; n++) begin
         mode  = $urandom_range(0, 9);
         a     = DW'($urandom);
         b     = SW'($urandom_range(1, 4095));
         if (mode == 0) b = '0;
         if (mode == 1) b = 12'd4095;
         if (mode == 2) a = DW'($urandom_range(0, 32'(b)));
         stall = $urandom_range(0, 2);
         model(a, b, eq, er, edz, elat);
         run_op(a, b, stall, q, r, dz, lat, uns, pov, pir, tmo);
         checks++;
         if (tmo || q !== eq || r !== er || dz !== edz) begin
            errors++;
            $display("FAIL rand_result: %0d/%0d got q=%0d r=%0d dz=%b expected %0d %0d %b",
                     a, b, q, r, dz, eq, er, edz);
         end
         checks++;
         if (lat != elat || uns != 0 || pov !== 1'b0 || pir !== 1'b1) begin
            errors++;
            $display("FAIL rand_timing: %0d/%0d got lat=%0d uns=%0d ov=%b ir=%b expected %0d 0 0 1",
                     a, b, lat, uns, pov, pir, elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_handshake();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
